// File: rtl/aes_inv_key_sched_if.sv
// Round-key stream bundle for the AES-128 inverse key schedule.
// master drives the request side, slave is the scheduler.
interface aes_inv_key_sched_if;
  logic         start;
  logic         key_is_cipher;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  modport master (
    output start,
    output key_is_cipher,
    output key_in,
    output rk_ready,
    input  rk_valid,
    input  rk_out,
    input  rk_round,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  key_is_cipher,
    input  key_in,
    input  rk_ready,
    output rk_valid,
    output rk_out,
    output rk_round,
    output busy,
    output done
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: emits round keys 10 down to 0.
// Keys are row-major, byte (r,c) at MSB-first offset 32r+8c.
module aes_inv_key_sched (
  input logic                clk,
  input logic                rst_n,
  aes_inv_key_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRECOMP,
    EMIT
  } state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(
    input logic [31:0] w
  );
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] i
  );
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Column c is {row0,row1,row2,row3} with row0 as the MS byte.
  function automatic logic [31:0] get_col(
    input logic [127:0] k,
    input int           c
  );
    logic [31:0] w;
    w = '0;
    for (int r = 0; r < 4; r++)
      w[31 - 8*r -: 8] = k[127 - 32*r - 8*c -: 8];
    return w;
  endfunction

  function automatic logic [127:0] put_cols(
    input logic [31:0] w0,
    input logic [31:0] w1,
    input logic [31:0] w2,
    input logic [31:0] w3
  );
    logic [127:0] k;
    logic [31:0]  w [4];
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    w[3] = w3;
    k = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        k[127 - 32*r - 8*c -: 8] = w[c][31 - 8*r -: 8];
    return k;
  endfunction

  state_e       state_q, state_d;
  logic [127:0] cur_q, cur_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  logic [31:0]  c0, c1, c2, c3;
  logic [31:0]  sb_in, sb_out, rc_w;
  logic [3:0]   rc_idx;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  p0, p1, p2, p3;
  logic [127:0] fwd_key, inv_key;
  logic         emit;

  assign c0 = get_col(cur_q, 0);
  assign c1 = get_col(cur_q, 1);
  assign c2 = get_col(cur_q, 2);
  assign c3 = get_col(cur_q, 3);

  assign p3 = c3 ^ c2;
  assign p2 = c2 ^ c1;
  assign p1 = c1 ^ c0;

  // One S-box word serves both directions; only its operand moves.
  assign sb_in  = (state_q == PRECOMP) ? rot_word(c3)
                                       : rot_word(p3);
  assign sb_out = sub_word(sb_in);

  assign rc_idx = (state_q == PRECOMP) ? rnd_q + 4'd1
                                       : rnd_q;
  assign rc_w   = {rcon(rc_idx), 24'h0};

  assign f0 = c0 ^ sb_out ^ rc_w;
  assign f1 = c1 ^ f0;
  assign f2 = c2 ^ f1;
  assign f3 = c3 ^ f2;
  assign p0 = c0 ^ sb_out ^ rc_w;

  assign fwd_key = put_cols(f0, f1, f2, f3);
  assign inv_key = put_cols(p0, p1, p2, p3);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cur_d = bus.key_in;
          if (bus.key_is_cipher) begin
            rnd_d   = 4'd0;
            state_d = PRECOMP;
          end else begin
            rnd_d   = 4'd10;
            state_d = EMIT;
          end
        end
      end
      PRECOMP: begin
        cur_d = fwd_key;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q >= 4'd9) begin
          rnd_d   = 4'd10;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.rk_ready) begin
          if (rnd_q != 4'd0) begin
            cur_d = inv_key;
            rnd_d = rnd_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rnd_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  assign emit         = (state_q == EMIT);
  assign bus.rk_valid = emit;
  assign bus.rk_out   = emit ? cur_q : '0;
  assign bus.rk_round = emit ? rnd_q : 4'd0;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched.
// Expected keys come from a forward AES-128 expansion model.
module tb_aes_inv_key_sched;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  localparam logic [127:0] K0  =
    128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
  localparam logic [127:0] R10 =
    128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6;
  localparam logic [127:0] R9  =
    128'hac192857_77fad15c_66dc2900_f321416e;
  localparam logic [127:0] R1  =
    128'ha088232a_fa54a36c_fe2c3976_17b13905;

  logic clk;
  logic rst_n;
  bit   rdy_rand;
  bit   exp_done;
  bit   mon_en;
  int   n_cmp;
  int   n_err;
  exp_t sb [$];
  logic [127:0] mdl [11];

  aes_inv_key_sched_if bus ();

  aes_inv_key_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    bus.rk_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: x^254 in GF(2^8), then affine map.
  function automatic logic [7:0] sbm(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w[c][31 - 8*r -: 8] = k[127 - 32*r - 8*c -: 8];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbm(t[23:16]), sbm(t[15:8]),
             sbm(t[7:0]), sbm(t[31:24])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 11; n++)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          mdl[n][127 - 32*r - 8*c -: 8] = w[4*n + c][31 - 8*r -: 8];
  endtask

  task automatic push_exp(input logic [127:0] ck);
    exp_t e;
    expand(ck);
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      e.key = mdl[r];
      sb.push_back(e);
    end
  endtask

  task automatic issue(
    input bit           cipher,
    input logic [127:0] k,
    input logic [127:0] ck
  );
    @(posedge clk);
    #1;
    bus.start         = 1'b1;
    bus.key_is_cipher = cipher;
    bus.key_in        = k;
    push_exp(ck);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rk_valid && n < 40);
    chk(tag, n, lat);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < budget);
    chk(tag, bus.done, 1'b1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic wait_round(input logic [3:0] r, input bit need_rdy);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.rk_valid && bus.rk_round == r &&
                 (bus.rk_ready || !need_rdy)) && n < 200);
    if (n >= 200) chk("wait_round_timeout", 1'b0, 1'b1);
  endtask

  // Peek while stalled (stability), pop on the accepting cycle.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("done", bus.done, exp_done);
      exp_done = 1'b0;
      if (bus.rk_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", bus.rk_valid, 1'b0);
        end else begin
          chk("rk_round", bus.rk_round, sb[0].rnd);
          chk("rk_out", bus.rk_out, sb[0].key);
          if (bus.rk_ready) begin
            if (sb[0].rnd == 4'd0) exp_done = 1'b1;
            void'(sb.pop_front());
          end
        end
      end else begin
        chk("rk_out_idle", bus.rk_out, '0);
      end
    end
  end

  initial begin
    logic [127:0] k2;
    n_cmp = 0;
    n_err = 0;
    mon_en = 1'b0;
    rdy_rand = 1'b0;
    exp_done = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.key_is_cipher = 1'b0;
    bus.key_in = '0;
    #2;
    chk("rst_valid", bus.rk_valid, 1'b0);
    chk("rst_out", bus.rk_out, '0);
    chk("rst_round", bus.rk_round, 4'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    #20;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // V1: from the cipher key
    issue(1'b1, K0, K0);
    wait_valid("v1_latency", 11);
    chk("v1_busy", bus.busy, 1'b1);
    chk("v1_round10", bus.rk_out, R10);
    @(negedge clk);
    chk("v1_round9", bus.rk_out, R9);
    wait_round(4'd1, 1'b0);
    chk("v1_round1", bus.rk_out, R1);
    @(negedge clk);
    chk("v1_round0", bus.rk_out, K0);
    wait_done("v1_done", 40);
    @(negedge clk);
    chk("v1_done_once", bus.done, 1'b0);

    // V2: from the round-10 key
    issue(1'b0, R10, K0);
    wait_valid("v2_latency", 1);
    wait_done("v2_done", 40);

    // V3: random backpressure
    rdy_rand = 1'b1;
    issue(1'b0, R10, K0);
    wait_valid("v3_latency", 1);
    wait_done("v3_done", 400);
    rdy_rand = 1'b0;

    // V4: start while busy is ignored
    issue(1'b1, K0, K0);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.key_is_cipher = 1'b0;
    bus.key_in = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_round(4'd8, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("v4_done", 60);
    repeat (4) @(negedge clk);
    chk("v4_idle_busy", bus.busy, 1'b0);

    // V5: reset in the middle of EMIT
    issue(1'b0, R10, K0);
    wait_round(4'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("v5_valid", bus.rk_valid, 1'b0);
    chk("v5_out", bus.rk_out, '0);
    chk("v5_round", bus.rk_round, 4'd0);
    chk("v5_busy", bus.busy, 1'b0);
    chk("v5_done", bus.done, 1'b0);
    sb.delete();
    exp_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("v5_post_busy", bus.busy, 1'b0);
    end
    issue(1'b0, R10, K0);
    wait_valid("v5_latency", 1);
    wait_done("v5_done_seq", 40);

    // V6: start on the done cycle, then a random key both ways
    k2 = {$urandom, $urandom, $urandom, $urandom};
    issue(1'b0, R10, K0);
    wait_round(4'd0, 1'b1);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.key_is_cipher = 1'b1;
    bus.key_in = k2;
    push_exp(k2);
    @(negedge clk);
    chk("v6_done_cycle", bus.done, 1'b1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_valid("v6_latency", 11);
    wait_done("v6_done", 40);
    issue(1'b0, mdl[10], k2);
    wait_valid("v6_inv_latency", 1);
    wait_done("v6_inv_done", 40);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start request, sampled only in IDLE
- key_is_cipher  in  1  sampled with start; 1 = key_in is the cipher key (round 0), 0 = key_in is the round-10 key
- key_in  in  128  input key, sampled with start
- rk_ready  in  1  downstream accepts rk_out
- rk_valid  out  1  rk_out/rk_round valid
- rk_out  out  128  current round key
- rk_round  out  4  round index of rk_out (10..0)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after round 0 is accepted

REQ-002 All 128-bit keys SHALL use bit 0 as MSB and a row-major byte layout: byte (row r, column c) = bits [32r+8c +: 8]; column c = {row0, row1, row2, row3} bytes.

Function
REQ-003 The FSM SHALL have states IDLE, PRECOMP and EMIT.
REQ-004 IDLE with start=1 SHALL latch key_in into the key register cur and set rnd=0 if key_is_cipher=1 (next state PRECOMP), or set rnd=10 if key_is_cipher=0 (next state EMIT).
REQ-005 PRECOMP SHALL apply one forward expansion round per cycle, with rnd incrementing by 1:
- c0' = c0 ^ SubWord(RotWord(c3)) ^ Rcon(rnd+1)
- ci' = ci ^ c(i-1)'
The FSM SHALL go to EMIT on the cycle rnd becomes 10, so PRECOMP lasts exactly 10 cycles.
REQ-006 Rcon(i) for i=1..10 SHALL be {01,02,04,08,10,20,40,80,1b,36} in byte 0 of the word, with the other three bytes zero.
REQ-007 RotWord SHALL move byte 0 to byte 3. SubWord SHALL apply the standard AES forward S-box to each byte. A single 4-byte S-box instance SHALL be shared by PRECOMP and EMIT.
REQ-008 EMIT SHALL drive rk_valid=1, rk_out=cur and rk_round=rnd.
REQ-009 rk_out and rk_round SHALL hold stable while rk_valid=1 and rk_ready=0.
REQ-010 On an EMIT cycle with rk_ready=1 and rnd>0, the block SHALL apply one inverse round and decrement rnd:
- p3 = c3 ^ c2
- p2 = c2 ^ c1
- p1 = c1 ^ c0
- p0 = c0 ^ SubWord(RotWord(p3)) ^ Rcon(rnd)
REQ-011 On an EMIT cycle with rk_ready=1 and rnd=0, the block SHALL go to IDLE and assert done for exactly the next cycle.
REQ-012 With rk_ready held at 1, the block SHALL emit rounds 10..0 on 11 consecutive cycles.
REQ-013 Latency:
- key_is_cipher=0: first rk_valid in the cycle after start is sampled.
- key_is_cipher=1: first rk_valid 11 cycles after start is sampled.
REQ-014 start SHALL be ignored while busy=1, and the in-flight sequence SHALL be unaffected.
REQ-015 start may coincide with the done cycle; because the FSM is in IDLE then, the block SHALL accept it.
REQ-016 rk_valid SHALL be 0 in IDLE and PRECOMP.
REQ-017 rk_out SHALL output zero whenever rk_valid=0.
REQ-018 rnd SHALL never leave the range 0..10, and no Rcon index outside 1..10 SHALL be used.

Reset
REQ-019 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state = IDLE
- cur = 0, rnd = 0
- rk_valid = 0, rk_out = 0, rk_round = 0
- busy = 0, done = 0
REQ-020 Reset asserted mid-PRECOMP or mid-EMIT SHALL abort the sequence. After release, no rk_valid SHALL occur until a new start.
REQ-021 Reset release SHALL be synchronized externally; the block SHALL take no action on the release edge other than resuming in IDLE.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- V1: key_is_cipher=1, key_in=2b28ab09_7eaef7cf_15d2154f_16a6883c, rk_ready=1 -> after 11 cycles, rk_round=10, rk_out=d0c9e1b6_14ee3f63_f9250c0c_a889c8a6; then round 9 = ac192857_77fad15c_66dc2900_f321416e, ..., round 1 = a088232a_fa54a36c_fe2c3976_17b13905, round 0 = key_in; done pulses once.
- V2: key_is_cipher=0, key_in=d0c9e1b6_14ee3f63_f9250c0c_a889c8a6 -> rk_valid in the next cycle with round 10; the sequence ends with round 0 = 2b28ab09_7eaef7cf_15d2154f_16a6883c.
- V3: V2 with rk_ready toggled randomly -> each round is presented exactly once, outputs are stable while stalled, and the sequence matches V2.
- V4: start pulsed during PRECOMP and during EMIT with a different key -> ignored; outputs match V1.
- V5: rst_n pulsed at round 5 of EMIT -> all outputs 0 asynchronously; IDLE after release; a new start gives the full V2 sequence.
- V6: start asserted on the done cycle -> the new sequence begins without an idle gap.
